eth_tx_buf_reader: RTL
======================

# eth_tx_buf_reader

Transmit-side drain engine for the 16/64-bit asymmetric packet buffer. Software writes a frame through the buffer's 64-bit port, then pulses `start_i` with a word base address and a byte length. The block reads the frame back through the 16-bit port and emits it as an 8-bit AXI-Stream toward the MAC transmitter. RAM read latency and stream backpressure are absorbed by a 2-entry word FIFO.

## Interface
- `ADDR_W`, 11: 16-bit word address width of the buffer's narrow port.
- `LEN_W`, 12: frame byte-count width.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: single-cycle frame start request; sampled only in IDLE.
- `base_i` in ADDR_W: word address of byte 0; sampled with `start_i`.
- `len_i` in LEN_W: frame length in bytes; sampled with `start_i`.
- `busy_o` out 1: high from the cycle after an accepted start until the last byte handshake.
- `done_o` out 1: one-cycle pulse, frame complete.
- `ram_en_o` out 1: narrow-port read enable.
- `ram_addr_o` out ADDR_W: narrow-port word address.
- `ram_rdata_i` in 16: narrow-port read data, valid the cycle after `ram_en_o`.
- `tx_tdata_o` out 8: stream byte.
- `tx_tvalid_o` out 1: stream valid.
- `tx_tready_i` in 1: stream ready.
- `tx_tlast_o` out 1: final byte of frame.

## Operation
- **Byte order:** byte n is at word `base+(n>>1)`, lane `n[0]`. Lane 0 is `[7:0]` and is sent first.
- **FSM states:**
  - IDLE: on `start_i` with `len_i != 0`, go to RUN. On `start_i` with `len_i == 0`, pulse `done_o` next cycle and stay in IDLE.
  - RUN: on the handshake of the last byte, go to IDLE.
- **Start while busy:** `start_i` while busy is ignored.
- **Word count:** words = `ceil(len/2)`.
- **Read issue:** in RUN, a read is issued when `words_issued < words` and `fifo_count + inflight < 2`.
  - The address increments modulo `2**ADDR_W`, so it wraps 2047→0.
- **Output:** byte mux selects the lane of the FIFO head word.
  - The FIFO pops after lane 1 is accepted, or after lane 0 is accepted when that byte is the last byte of an odd-length frame. The unused high lane is discarded.
- **Stream rules:**
  - `tx_tdata_o` and `tx_tlast_o` hold stable while `tx_tvalid_o & !tx_tready_i`.
  - `tx_tvalid_o` never drops before its handshake.
  - `tx_tlast_o` is high only with the final byte.
- **Length arithmetic:** byte counter is LEN_W wide and compared to the latched length. Lengths up to `2**LEN_W-1` are legal. Length is not bounds-checked against buffer size; addresses wrap.
- **Reset (any time, including mid-frame):**
  - All outputs go to 0 and state goes to IDLE.
  - The FIFO is flushed and counters are cleared.
  - Any in-flight RAM data returning after reset is ignored.

## Timing
- **Start-to-data latency:** start sampled at edge of cycle T → `ram_en_o=1`, `ram_addr_o=base` in T+1 → data in T+2, captured into FIFO → first `tx_tvalid_o` in T+3.
- **Throughput:** with `tx_tready_i` held high, one byte per cycle sustained, no bubbles.
- **Completion:** `done_o` pulses in the cycle after the last byte handshake. `busy_o` falls in that same cycle.
- **Read throttling:** `ram_en_o` is never asserted when `fifo_count + inflight == 2`. No FIFO overflow under any `tx_tready_i` pattern.

## Configuration
- **`ETH_TX_PAD_EN` defined:**
  - Frames shorter than 60 bytes are extended to 60 bytes with 0x00 pad bytes.
  - Pad bytes are generated internally; no RAM reads occur for them.
  - `tx_tlast_o` is on byte 60.
  - `len == 0` still completes with no bytes.
- **Not defined:** exactly `len` bytes are emitted, with no padding logic.

## Structure
- **Package `eth_tx_pkg`:** FSM state enum (IDLE, RUN), `ETH_MIN_FRAME_LEN = 60`, default `ADDR_W`/`LEN_W` constants.
- **Sub-module `eth_tx_word_fifo`:** 2-entry, 16-bit, synchronous FIFO with push/pop/count outputs.
- **Top:** holds the FSM, address and byte counters, inflight tracking, and the lane mux.

## Test plan
- **Basic frame:** words 0x2211, 0x4433 at base 0, `len=4`, `tready=1` → bytes 11,22,33,44 on consecutive cycles starting T+3. `tlast` on 44. `done_o` next cycle. Exactly 2 reads (addr 0, 1).
- **Odd length:** `len=5`, word 2 = 0xAA55 → fifth byte 0x55 with `tlast`. 0xAA never emitted. 3 reads.
- **Backpressure:** `len=8`, `tready` pattern 1,0,1,0… → 8 bytes in order, none dropped or duplicated. Data stable while stalled. Never more than 2 words buffered plus in flight.
- **Wrap and zero length:**
  - `base=2047`, `len=4` → reads addr 2047 then 0.
  - `len=0` → `done_o` at T+1, no `ram_en_o`, no `tvalid`.
  - `start_i` during RUN ignored.
- **Reset mid-frame:** assert `rst` after 3 of 8 bytes → all outputs 0 next cycle. A subsequent start of `len=2` at base 0 emits the word at addr 0 only.
- **Padding (`ETH_TX_PAD_EN`):** `len=10` → 60 bytes; bytes 10–59 are 0x00; `tlast` on byte 60; exactly 5 RAM reads.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the transmit buffer drain engine.
package eth_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int ETH_MIN_FRAME_LEN = 60;
    localparam int ETH_ADDR_W        = 11;
    localparam int ETH_LEN_W         = 12;
    localparam int ETH_FIFO_DEPTH    = 2;

endpackage

// File: rtl/eth_tx_word_fifo.sv
// Two-entry 16-bit word FIFO between the buffer read port and the byte lane mux.
module eth_tx_word_fifo
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] din,
    output logic [15:0] head,
    output logic [1:0]  count
);

    logic [15:0] mem [ETH_FIFO_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/eth_tx_buf_reader.sv
// Drains a frame from the 16-bit buffer port onto an 8-bit AXI-Stream.
// Optional ETH_TX_PAD_EN: zero-pads short frames to the minimum Ethernet length.
//
// state | meaning
// IDLE  | waiting for start_i; zero-length start just pulses done_o
// RUN   | issuing word reads and streaming bytes until the last handshake
module eth_tx_buf_reader
    import eth_tx_pkg::*;
#(
    parameter int ADDR_W = ETH_ADDR_W,
    parameter int LEN_W  = ETH_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [15:0]       ram_rdata_i,
    output logic [7:0]        tx_tdata_o,
    output logic              tx_tvalid_o,
    input  logic              tx_tready_i,
    output logic              tx_tlast_o
);

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  words_q;
    logic [LEN_W-1:0]  words_issued;
    logic [LEN_W-1:0]  bcnt;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight;
    logic [1:0]        fifo_count;
    logic [15:0]       fifo_head;
    logic [7:0]        lane;
    logic              in_data;
    logic              issue;
    logic              hs;
    logic              last_byte;
    logic              pop;

    eth_tx_word_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (ram_rdata_i),
        .head  (fifo_head),
        .count (fifo_count)
    );

    // Budget of two words covers both the FIFO and the read in flight.
    assign issue = (state == RUN) && (words_issued < words_q) &&
                   ((fifo_count + {1'b0, inflight}) < 2'd2);

    assign ram_en_o   = issue;
    assign ram_addr_o = addr_q;
    assign busy_o     = (state == RUN);

    assign in_data = (bcnt < len_q);
    assign lane    = bcnt[0] ? fifo_head[15:8] : fifo_head[7:0];
    assign hs      = tx_tvalid_o && tx_tready_i;
    assign pop     = hs && in_data && (bcnt[0] || (bcnt == len_q - LEN_W'(1)));

`ifdef ETH_TX_PAD_EN
    logic [LEN_W-1:0] total_q;

    assign last_byte   = (bcnt == total_q - LEN_W'(1));
    assign tx_tvalid_o = (state == RUN) && (!in_data || (fifo_count != 2'd0));
    assign tx_tdata_o  = ((state == RUN) && in_data) ? lane : 8'h00;
`else
    assign last_byte   = (bcnt == len_q - LEN_W'(1));
    assign tx_tvalid_o = (state == RUN) && (fifo_count != 2'd0);
    assign tx_tdata_o  = (state == RUN) ? lane : 8'h00;
`endif

    assign tx_tlast_o = (state == RUN) && last_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len_q        <= '0;
            words_q      <= '0;
            words_issued <= '0;
            bcnt         <= '0;
            addr_q       <= '0;
            inflight     <= 1'b0;
            done_o       <= 1'b0;
`ifdef ETH_TX_PAD_EN
            total_q      <= '0;
`endif
        end else begin
            done_o   <= 1'b0;
            inflight <= issue;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            state        <= RUN;
                            len_q        <= len_i;
                            words_q      <= {1'b0, len_i[LEN_W-1:1]} +
                                            {{(LEN_W-1){1'b0}}, len_i[0]};
                            words_issued <= '0;
                            bcnt         <= '0;
                            addr_q       <= base_i;
`ifdef ETH_TX_PAD_EN
                            total_q      <= (len_i < LEN_W'(ETH_MIN_FRAME_LEN)) ?
                                            LEN_W'(ETH_MIN_FRAME_LEN) : len_i;
`endif
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q       <= addr_q + ADDR_W'(1);
                        words_issued <= words_issued + LEN_W'(1);
                    end
                    if (hs) begin
                        bcnt <= bcnt + LEN_W'(1);
                        if (last_byte) begin
                            state  <= IDLE;
                            done_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
